// File: rtl/divisor.sv
// Sequential 3-bit unsigned restoring divider: one quotient bit per SHIFT/SUB
// pair, registered quotient/remainder/divide-by-zero flag, one-cycle done pulse.
module divisor (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic [2:0] DV,
  input  logic [2:0] DR,
  output logic [2:0] C,
  output logic [2:0] R,
  output logic       err,
  output logic       done,
  output logic       busy,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [2:0] q_q, q_d;
  logic [2:0] d_q, d_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] c_q, c_d;
  logic [2:0] r_q, r_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  // A is one bit wider than D so the trial subtraction never overflows.
  logic       a_ge;
  logic [3:0] a_sub;
  assign a_ge  = (a_q >= {1'b0, d_q});
  assign a_sub = a_q - {1'b0, d_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    r_d     = r_q;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (init) begin
          if (DR == 3'd0) begin
            c_d     = 3'b111;
            r_d     = DV;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            q_d     = DV;
            d_d     = DR;
            a_d     = 4'd0;
            cnt_d   = 2'd3;
            busy_d  = 1'b1;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // A < D <= 7 holds here, so A[3] is always zero and nothing is lost.
        {a_d, q_d} = {a_q[2:0], q_q, 1'b0};
        state_d    = S_SUB;
      end
      S_SUB: begin
        if (a_ge) begin
          a_d = a_sub;
          q_d = {q_q[2:1], 1'b1};
        end
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          c_d     = q_d;
          r_d     = a_d[2:0];
          err_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 4'd0;
      q_q     <= 3'd0;
      d_q     <= 3'd0;
      cnt_q   <= 2'd0;
      c_q     <= 3'd0;
      r_q     <= 3'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      r_q     <= r_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign C       = c_q;
  assign R       = r_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign done    = (state_q == S_DONE);
  assign state_o = state_q;

endmodule
